// File: rtl/imm_encoder.sv
// RV32I instruction packer: scatters a 32-bit immediate into R/I/S/B/U/J encodings and flags unrepresentable values.
// Two-stage pipeline, 2-cycle latency, valid/ready backpressure; in_ready falls only when both stages are full and out is stalled.
module imm_encoder #(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               encoding,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [2:0]               funct3,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [6:0]               funct7,
  input  logic [31:0]              imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_range_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    ENC_R = 3'd0,
    ENC_I = 3'd1,
    ENC_S = 3'd2,
    ENC_B = 3'd3,
    ENC_U = 3'd4,
    ENC_J = 3'd5
  } enc_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        r_s1_valid;
  logic [2:0]  r_s1_enc;
  logic [6:0]  r_s1_opcode;
  logic [4:0]  r_s1_rd;
  logic [2:0]  r_s1_funct3;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [6:0]  r_s1_funct7;
  logic [31:0] r_s1_imm;

  logic                     r_s2_valid;
  logic [31:0]              r_s2_instr;
  logic                     r_s2_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic        w_s2_load;
  logic        w_s1_load;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_i_ok;
  logic        w_b_ok;
  logic        w_u_ok;
  logic        w_j_ok;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  // Pipeline is flushed while reset is held, so it can always take a bundle then.
  assign in_ready  = !reset_n || w_s1_load;

  assign out_valid     = r_s2_valid;
  assign out_instr     = r_s2_instr;
  assign out_range_err = r_s2_err;
  assign err_count     = r_err_count;

  assign w_i_ok = (r_s1_imm[31:11] == {21{r_s1_imm[11]}});
  assign w_b_ok = !r_s1_imm[0] && (r_s1_imm[31:12] == {20{r_s1_imm[12]}});
  assign w_u_ok = (r_s1_imm[11:0] == 12'd0);
  assign w_j_ok = !r_s1_imm[0] && (r_s1_imm[31:20] == {12{r_s1_imm[20]}});

  always_comb begin
    w_instr = NOP_WORD;
    w_err   = 1'b1;
    case (r_s1_enc)
      ENC_R: begin
        w_instr = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
        w_err   = 1'b0;
      end
      ENC_I: begin
        w_instr = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
        w_err   = !w_i_ok;
      end
      ENC_S: begin
        w_instr = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:0], r_s1_opcode};
        w_err   = !w_i_ok;
      end
      ENC_B: begin
        w_instr = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                   r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
        w_err   = !w_b_ok;
      end
      ENC_U: begin
        w_instr = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
        w_err   = !w_u_ok;
      end
      ENC_J: begin
        w_instr = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                   r_s1_rd, r_s1_opcode};
        w_err   = !w_j_ok;
      end
      default: begin
        w_instr = NOP_WORD;
        w_err   = 1'b1;
      end
    endcase
  end

  // S1 payload carries no reset; it is only consumed when r_s1_valid is set.
  always_ff @(posedge clk) begin
    if (in_valid && w_s1_load) begin
      r_s1_enc    <= encoding;
      r_s1_opcode <= opcode;
      r_s1_rd     <= rd;
      r_s1_funct3 <= funct3;
      r_s1_rs1    <= rs1;
      r_s1_rs2    <= rs2;
      r_s1_funct7 <= funct7;
      r_s1_imm    <= imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_instr  <= 32'd0;
      r_s2_err    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_instr;
          r_s2_err   <= w_err;
        end
      end
      if (r_s2_valid && out_ready && r_s2_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Instruction-word packer: the inverse of immediate generation. Takes decoded fields plus a 32-bit immediate and produces the RV32I instruction word, scattering the immediate bits to their encoding positions.
- Each word carries a flag saying whether the immediate was representable in that encoding.
- Used by the boot/debug loader and the self-test instruction injector. Sits between the field source and the instruction memory write port.
- Two-stage pipeline with valid/ready backpressure and a saturating error counter.

Parameters:
ERR_CNT_WIDTH, 8, width of the saturating range-error counter

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept the bundle this cycle
encoding  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are reserved
opcode  input  7  inst[6:0]
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  funct7 field
imm  input  32  immediate, byte offset for B/J, full value for U
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts the word
out_instr  output  32  encoded instruction word
out_range_err  output  1  immediate not representable; word still emitted with imm truncated
err_count  output  ERR_CNT_WIDTH  number of accepted words with range_err, saturating

Behaviour:
- Clocking: all state updates on the rising edge of clk. Synchronous active-low reset. reset_n=0 clears the stage valids, out_valid, out_instr, out_range_err and err_count to 0. in_ready is 1 while reset_n=0.
- Stage 1 (S1): registers the input bundle when in_valid && in_ready.
- Stage 2 (S2): registers the packed word and the range flag. S2 drives out_* directly from registers.
- Latency: a bundle accepted in cycle N appears on out_* in cycle N+2 when there is no stall.
- Advance rules:
  - S2 loads when (!s2_valid || out_ready).
  - S1 loads when (!s1_valid || S2 loads).
  - in_ready = !s1_valid || S2 loads.
  - Full throughput is one word per cycle.
- Stall: while out_valid && !out_ready, out_instr and out_range_err hold stable, and no bundle is lost or duplicated.
- Simultaneous events: in_valid && in_ready together with out_valid && out_ready moves both stages in the same cycle.
- Packing, per encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range check (computed in S2), per encoding:
  - I/S: error unless imm[31:11] are all equal to imm[11].
  - B: error if imm[0]=1, or unless imm[31:12] are all equal to imm[12].
  - U: error if imm[11:0] != 0.
  - J: error if imm[0]=1, or unless imm[31:20] are all equal to imm[20].
  - R: never an error; imm is ignored.
- Reserved encoding (6/7): out_instr = 32'h0000_0013 (NOP), out_range_err=1.
- err_count:
  - Increments by 1 on each handshake (out_valid && out_ready) where out_range_err=1.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Reset mid-operation: in-flight bundles are discarded. The first cycle after reset_n returns to 1 has in_ready=1 and out_valid=0.

Test Plan:
- I-type addi x1,x2,-1: encoding=1, opcode=0x13, rd=1, funct3=0, rs1=2, imm=0xFFFFFFFF -> out_instr=0xFFF10093, err=0, out_valid two cycles after acceptance.
- S-type sw x5,8(x2): encoding=2, opcode=0x23, funct3=2, rs1=2, rs2=5, imm=8 -> 0x00512423, err=0. B-type beq x0,x0,-4: encoding=3, opcode=0x63, imm=0xFFFFFFFC -> 0xFE000EE3, err=0.
- U-type lui x1: encoding=4, opcode=0x37, rd=1.
  - imm=0x12345000 -> 0x123450B7, err=0.
  - imm=0x12345001 -> 0x123450B7, err=1, err_count=1.
- Range errors:
  - I with imm=0x800 -> err=1.
  - B with imm=6 -> err=0.
  - B with imm=3 -> err=1.
  - Reserved encoding 7 -> 0x00000013, err=1.
- Backpressure: stream 5 bundles with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, out_instr is stable while stalled, all 5 words arrive in order exactly once. Force 300 errored words -> err_count holds at 0xFF.
- Reset: assert reset_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, err_count=0, in_ready=1, and no stale word is emitted afterwards.
